// File: rtl/vsm_control_unit.sv
// VSM control unit: fetch/decode/execute sequencer driving PC and accumulator.
// Optional single-step mode via VSM_SINGLE_STEP_EN (adds the Step input).
module vsm_control_unit #(
    parameter int ROM_LAT   = 1,
    parameter int WRAP_HALT = 1
) (
    input  logic       MainClock,
    input  logic       ClearSystem,
    input  logic       Run,
`ifdef VSM_SINGLE_STEP_EN
    input  logic       Step,
`endif
    input  logic [3:0] PC,
    input  logic [7:0] Instr,
    input  logic       AccZero,
    output logic       EnableCount,
    output logic       ClearCounter,
    output logic [7:0] IR,
    output logic [1:0] AccOp,
    output logic       AccStrobe,
    output logic [3:0] Operand,
    output logic       Halted,
    output logic       WrapFlag
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXEC,
        ADVANCE,
        HALT
    } stateT;

    localparam logic [1:0] LatLast = 2'(ROM_LAT - 1);

    stateT      state;
    stateT      nextState;
    logic [1:0] fetchCnt;
    logic [1:0] fetchCntNext;
    logic [7:0] irNext;
    logic [1:0] opNext;
    logic       strobeNext;
    logic       clrNext;
    logic       wrapNext;
    logic       start;
    stateT      resume;

`ifdef VSM_SINGLE_STEP_EN
    logic stepQ;
    logic stepPend;
    logic stepAvail;

    // A Step rising edge arms exactly one instruction; it is consumed on start.
    always_ff @(posedge MainClock) begin
        if (ClearSystem) begin
            stepQ    <= 1'b0;
            stepPend <= 1'b0;
        end else begin
            stepQ    <= Step;
            stepPend <= stepAvail & ~start;
        end
    end

    assign stepAvail = stepPend | (Step & ~stepQ);
    assign start     = Run & stepAvail;
    assign resume    = IDLE;
`else
    assign start  = Run;
    assign resume = Run ? FETCH : IDLE;
`endif

    // Next-state and next-output decode; outputs are registered below.
    always_comb begin
        nextState    = state;
        fetchCntNext = 2'd0;
        irNext       = IR;
        opNext       = AccOp;
        strobeNext   = 1'b0;
        clrNext      = 1'b0;
        wrapNext     = WrapFlag;
        unique case (state)
            IDLE: begin
                if (start) nextState = FETCH;
            end
            FETCH: begin
                if (fetchCnt == LatLast) nextState = DECODE;
                else fetchCntNext = fetchCnt + 2'd1;
            end
            DECODE: begin
                irNext    = Instr;
                nextState = EXEC;
                // Strobe is timed to be high during EXEC.
                case (Instr[7:4])
                    4'h1: begin strobeNext = 1'b1; opNext = 2'b00; end
                    4'h2: begin strobeNext = 1'b1; opNext = 2'b01; end
                    4'h3: begin strobeNext = 1'b1; opNext = 2'b10; end
                    4'h5: begin strobeNext = 1'b1; opNext = 2'b11; end
                    default: ;
                endcase
            end
            EXEC: begin
                if (IR[7:4] == 4'hF) begin
                    nextState = HALT;
                end else if (IR[7:4] == 4'h4 && AccZero) begin
                    // Clear lands before the ROM is sampled in DECODE.
                    clrNext   = 1'b1;
                    nextState = resume;
                end else begin
                    nextState = ADVANCE;
                end
            end
            ADVANCE: begin
                nextState = resume;
                if (PC == 4'hF) begin
                    wrapNext = 1'b1;
                    if (WRAP_HALT != 0) nextState = HALT;
                end
            end
            HALT: nextState = HALT;
            default: nextState = IDLE;
        endcase
    end

    // State and registered outputs; reset forces the counter clear.
    always_ff @(posedge MainClock) begin
        if (ClearSystem) begin
            state        <= IDLE;
            fetchCnt     <= 2'd0;
            IR           <= 8'h00;
            AccOp        <= 2'b00;
            AccStrobe    <= 1'b0;
            EnableCount  <= 1'b0;
            ClearCounter <= 1'b1;
            Halted       <= 1'b0;
            WrapFlag     <= 1'b0;
        end else begin
            state        <= nextState;
            fetchCnt     <= fetchCntNext;
            IR           <= irNext;
            AccOp        <= opNext;
            AccStrobe    <= strobeNext;
            EnableCount  <= (nextState == ADVANCE);
            ClearCounter <= clrNext;
            Halted       <= (nextState == HALT);
            WrapFlag     <= wrapNext;
        end
    end

    assign Operand = IR[3:0];

endmodule

// File: tb/tb_vsm_control_unit.sv
// Directed bench for vsm_control_unit with a PC counter and ROM model.
// Two instances: default (WRAP_HALT=1) and a wrapping one (WRAP_HALT=0).
module tb_vsm_control_unit;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       run = 1'b1;
    logic       accZero = 1'b0;
`ifdef VSM_SINGLE_STEP_EN
    logic       step = 1'b0;
`endif
    logic [3:0] pc, pcW;
    logic [7:0] rom [16];
    logic [7:0] instr, instrW;

    logic       en, clrOut, strobe, halted, wrap;
    logic [7:0] ir;
    logic [1:0] op;
    logic [3:0] operand;
    logic       enW, clrOutW, strobeW, haltedW, wrapW;
    logic [7:0] irW;
    logic [1:0] opW;
    logic [3:0] operandW;

    int checks = 0;
    int failures = 0;
    int cyc, nStrobe, nEn, nClr, nEnW, nStrobeW;
    int sc [3];
    logic [1:0] sop [3];
    logic [3:0] sopd [3];
    logic [1:0] lastOp;
    logic [3:0] lastOperand;

    always #5 clk = ~clk;

    assign instr  = rom[pc];
    assign instrW = rom[pcW];

    always_ff @(posedge clk) begin
        if (clrOut) pc <= 4'd0;
        else if (en) pc <= pc + 4'd1;
        if (clrOutW) pcW <= 4'd0;
        else if (enW) pcW <= pcW + 4'd1;
    end

    vsm_control_unit dut (
        .MainClock(clk), .ClearSystem(clr), .Run(run),
`ifdef VSM_SINGLE_STEP_EN
        .Step(step),
`endif
        .PC(pc), .Instr(instr), .AccZero(accZero),
        .EnableCount(en), .ClearCounter(clrOut), .IR(ir),
        .AccOp(op), .AccStrobe(strobe), .Operand(operand),
        .Halted(halted), .WrapFlag(wrap)
    );

    vsm_control_unit #(.ROM_LAT(1), .WRAP_HALT(0)) dutW (
        .MainClock(clk), .ClearSystem(clr), .Run(run),
`ifdef VSM_SINGLE_STEP_EN
        .Step(step),
`endif
        .PC(pcW), .Instr(instrW), .AccZero(accZero),
        .EnableCount(enW), .ClearCounter(clrOutW), .IR(irW),
        .AccOp(opW), .AccStrobe(strobeW), .Operand(operandW),
        .Halted(haltedW), .WrapFlag(wrapW)
    );

    typedef struct {
        logic [7:0] instr;
        logic       az;
        int         strobes;
        logic [1:0] op;
        int         ens;
        int         clrs;
        logic       halted;
    } vecT;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (strobe) begin
            if (nStrobe < 3) begin
                sc[nStrobe]   = cyc;
                sop[nStrobe]  = op;
                sopd[nStrobe] = operand;
            end
            lastOp      = op;
            lastOperand = operand;
            nStrobe++;
        end
        if (en) nEn++;
        if (clrOut) nClr++;
        if (enW) nEnW++;
        if (strobeW) nStrobeW++;
    endtask

    task automatic clearMon();
        cyc = 0; nStrobe = 0; nEn = 0; nClr = 0; nEnW = 0; nStrobeW = 0;
        lastOp = 2'b00; lastOperand = 4'd0;
        for (int i = 0; i < 3; i++) begin
            sc[i] = 0; sop[i] = 2'b00; sopd[i] = 4'd0;
        end
    endtask

    task automatic doReset(input int n);
        clr = 1'b1;
        repeat (n) tick();
        clr = 1'b0;
        clearMon();
    endtask

    task automatic loadRom(input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] c, input logic [7:0] d,
                           input logic [7:0] rest);
        for (int i = 0; i < 16; i++) rom[i] = rest;
        rom[0] = a; rom[1] = b; rom[2] = c; rom[3] = d;
    endtask

    vecT vecs [10];

    initial begin
        vecs[0] = '{8'h13, 1'b0, 1, 2'b00, 1, 0, 1'b0};
        vecs[1] = '{8'h22, 1'b0, 1, 2'b01, 1, 0, 1'b0};
        vecs[2] = '{8'h31, 1'b0, 1, 2'b10, 1, 0, 1'b0};
        vecs[3] = '{8'h5A, 1'b0, 1, 2'b11, 1, 0, 1'b0};
        vecs[4] = '{8'h07, 1'b1, 0, 2'b00, 1, 0, 1'b0};
        vecs[5] = '{8'h45, 1'b1, 0, 2'b00, 0, 1, 1'b0};
        vecs[6] = '{8'h45, 1'b0, 0, 2'b00, 1, 0, 1'b0};
        vecs[7] = '{8'hF0, 1'b0, 0, 2'b00, 0, 0, 1'b1};
        vecs[8] = '{8'h9C, 1'b1, 0, 2'b00, 1, 0, 1'b0};
        vecs[9] = '{8'h6E, 1'b0, 0, 2'b00, 1, 0, 1'b0};

        loadRom(8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        clearMon();

        // Reset held 3 cycles with Run=1.
        clr = 1'b1; run = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_clear", 32'(clrOut), 32'd1);
            chk("rst_enable", 32'(en), 32'd0);
            chk("rst_halted", 32'(halted), 32'd0);
            chk("rst_ir", 32'(ir), 32'h00);
            chk("rst_wrap", 32'(wrap), 32'd0);
        end
        clr = 1'b0;
        tick();
        chk("rst_release_clear", 32'(clrOut), 32'd0);

`ifndef VSM_SINGLE_STEP_EN
        // One instruction per vector: 4 cycles after reset release.
        foreach (vecs[k]) begin
            loadRom(vecs[k].instr, 8'hF0, 8'hF0, 8'hF0, 8'hF0);
            accZero = vecs[k].az;
            run = 1'b1;
            doReset(2);
            repeat (4) tick();
            chk($sformatf("vec%0d_strobes", k), 32'(nStrobe), 32'(vecs[k].strobes));
            chk($sformatf("vec%0d_op", k), 32'(lastOp), 32'(vecs[k].op));
            chk($sformatf("vec%0d_en", k), 32'(nEn), 32'(vecs[k].ens));
            chk($sformatf("vec%0d_clr", k), 32'(nClr), 32'(vecs[k].clrs));
            chk($sformatf("vec%0d_halt", k), 32'(halted), 32'(vecs[k].halted));
            chk($sformatf("vec%0d_ir", k), 32'(ir), 32'(vecs[k].instr));
        end

        // Sequential program ending in HLT.
        loadRom(8'h13, 8'h22, 8'h31, 8'hF0, 8'h00);
        accZero = 1'b0;
        doReset(2);
        while (!halted && cyc < 40) tick();
        chk("seq_halted", 32'(halted), 32'd1);
        chk("seq_strobes", 32'(nStrobe), 32'd3);
        chk("seq_gap1", 32'(sc[1] - sc[0]), 32'd4);
        chk("seq_gap2", 32'(sc[2] - sc[1]), 32'd4);
        chk("seq_ops", 32'({sop[0], sop[1], sop[2]}), 32'b00_01_10);
        chk("seq_operands", 32'({sopd[0], sopd[1], sopd[2]}), 32'h321);
        chk("seq_en", 32'(nEn), 32'd3);
        chk("seq_pc", 32'(pc), 32'd3);

        // JZ0 at PC=2, taken.
        loadRom(8'h00, 8'h00, 8'h40, 8'hF0, 8'h00);
        accZero = 1'b1;
        doReset(2);
        while (nClr == 0 && cyc < 30) tick();
        chk("jz_clr_seen", 32'(nClr), 32'd1);
        chk("jz_en_before", 32'(nEn), 32'd2);
        tick();
        chk("jz_clr_width", 32'(clrOut), 32'd0);
        chk("jz_pc_zero", 32'(pc), 32'd0);
        tick();
        chk("jz_refetch_ir", 32'(ir), 32'h00);
        chk("jz_no_extra_en", 32'(nEn), 32'd2);

        // JZ0 at PC=2, not taken.
        accZero = 1'b0;
        doReset(2);
        while (!halted && cyc < 40) tick();
        chk("jzn_halted", 32'(halted), 32'd1);
        chk("jzn_en", 32'(nEn), 32'd3);
        chk("jzn_pc", 32'(pc), 32'd3);
        chk("jzn_clr", 32'(nClr), 32'd0);

        // Wrap: all NOPs.
        loadRom(8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        doReset(2);
        for (int i = 0; i < 70; i++) begin
            tick();
            if (i == 59) chk("wrap_early", 32'(wrap), 32'd0);
        end
        chk("wrap_flag", 32'(wrap), 32'd1);
        chk("wrap_halted", 32'(halted), 32'd1);
        chk("wrap_en", 32'(nEn), 32'd16);
        chk("wrap_pc", 32'(pc), 32'd0);
        chk("wrapW_flag", 32'(wrapW), 32'd1);
        chk("wrapW_halted", 32'(haltedW), 32'd0);
        chk("wrapW_en", 32'(nEnW), 32'd17);
        chk("wrapW_pc", 32'(pcW), 32'd1);
        chk("wrapW_strobes", 32'(nStrobeW), 32'd0);
        chk("wrapW_ir", 32'({irW, opW, operandW}), 32'd0);

        // Run dropped during EXEC of 0x21.
        loadRom(8'h21, 8'h13, 8'hF0, 8'hF0, 8'hF0);
        run = 1'b1;
        doReset(2);
        repeat (3) tick();
        run = 1'b0;
        repeat (12) tick();
        chk("drop_strobes", 32'(nStrobe), 32'd1);
        chk("drop_op", 32'(lastOp), 32'b01);
        chk("drop_en", 32'(nEn), 32'd1);
        chk("drop_pc", 32'(pc), 32'd1);
        chk("drop_halted", 32'(halted), 32'd0);
        run = 1'b1;
        for (int i = 0; i < 10 && nStrobe < 2; i++) tick();
        chk("resume_strobes", 32'(nStrobe), 32'd2);
        chk("resume_op", 32'(lastOp), 32'b00);
        chk("resume_operand", 32'(lastOperand), 32'd3);
`else
        // Single-step: three Step edges, each held high for a while.
        loadRom(8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        run = 1'b1;
        step = 1'b0;
        doReset(2);
        repeat (10) tick();
        chk("step_wait", 32'(nEn), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step = 1'b1;
            repeat (12) tick();
            chk($sformatf("step%0d_en", i), 32'(nEn), 32'(i + 1));
            step = 1'b0;
            repeat (2) tick();
        end
        chk("step_en_total", 32'(nEn), 32'd3);
        chk("step_pc", 32'(pc), 32'd3);
        chk("stepW_pc", 32'(pcW), 32'd3);
        run = 1'b0;
        step = 1'b1;
        repeat (10) tick();
        chk("step_run_low", 32'(nEn), 32'd3);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vsm_control_unit.md
Name: vsm_control_unit

Overview:
- Sequencer for the VSM datapath. It is the initiator that drives the 4-bit program counter's EnableCount and ClearCounter inputs.
- It reads PC back, fetches the 8-bit instruction word from program ROM and decodes it. It then issues accumulator strobes and advances or clears the counter.
- Sits between the program counter, the program ROM and the accumulator/ALU.

Parameters:
- ROM_LAT, 1, cycles from a stable PC to valid Instr (1..3).
- WRAP_HALT, 1, 1 = halt when an advance occurs at PC=15; 0 = allow wrap to 0.

Ports:
- MainClock  input  1  system clock, rising-edge active.
- ClearSystem  input  1  synchronous active-high reset.
- Run  input  1  level; start and continue execution.
- PC  input  4  current program counter value.
- Instr  input  8  ROM data; [7:4] opcode, [3:0] operand.
- AccZero  input  1  accumulator equals zero.
- EnableCount  output  1  registered, one-cycle counter advance pulse.
- ClearCounter  output  1  registered counter clear.
- IR  output  8  latched instruction.
- AccOp  output  2  00 load, 01 add, 10 sub, 11 out.
- AccStrobe  output  1  one-cycle accumulator/ALU execute pulse.
- Operand  output  4  equals IR[3:0].
- Halted  output  1  high in the HALT state.
- WrapFlag  output  1  sticky; set on an advance issued at PC=15.

Behaviour:
- Clocking: one clock, MainClock. Reset ClearSystem is synchronous and active-high.
- Reset values: state IDLE, EnableCount 0, ClearCounter 1, IR 0x00, AccOp 00, AccStrobe 0, Halted 0, WrapFlag 0.
- ClearCounter stays 1 while ClearSystem is high and falls on the first cycle after reset release.
- All outputs are registered. EnableCount and ClearCounter are never high in the same cycle.
- States: IDLE, FETCH, DECODE, EXEC, ADVANCE, HALT.
- IDLE: move to FETCH when Run=1.
- FETCH: wait ROM_LAT cycles with PC stable, then go to DECODE.
- DECODE: IR <= Instr; go to EXEC.
- EXEC: decode IR[7:4]:
  - 0x0 NOP: no strobe.
  - 0x1 LDA: AccOp=00, AccStrobe=1.
  - 0x2 ADD: AccOp=01, AccStrobe=1.
  - 0x3 SUB: AccOp=10, AccStrobe=1.
  - 0x5 OUT: AccOp=11, AccStrobe=1.
  - 0x4 JZ0: if AccZero=1, assert ClearCounter for one cycle, skip ADVANCE and go to FETCH. If AccZero=0, treat as NOP.
  - 0xF HLT: go to HALT with no advance.
  - Undefined opcodes execute as NOP.
- ADVANCE: EnableCount=1 for exactly one cycle.
  - If PC=15, set WrapFlag. If WRAP_HALT=1, go to HALT, otherwise go to FETCH.
  - The new PC is assumed valid by the following FETCH cycle.
- Latency with ROM_LAT=1: 4 cycles per sequential instruction (FETCH, DECODE, EXEC, ADVANCE); 3 cycles for a taken JZ0.
- Run dropped mid-instruction: the current instruction completes through ADVANCE, then the block goes to IDLE. PC is not cleared.
- HALT: Halted=1 and all strobes 0. Only ClearSystem exits HALT.
- ClearSystem in any state: forced return to IDLE on the next edge. A pending EnableCount is suppressed and ClearCounter is asserted.
- Simultaneous Run rise and ClearSystem: ClearSystem wins.
- AccZero is sampled only in EXEC.

Optional Feature:
- Macro: VSM_SINGLE_STEP_EN.
- With the macro defined:
  - Add input Step (1 bit).
  - After ADVANCE (or a taken JZ0) the FSM waits in IDLE until a rising edge of Step, detected as a registered 0->1 transition, even if Run=1.
  - Each Step edge executes exactly one instruction.
  - Run=0 still stops execution.
- Without the macro: the Step port is absent and the FSM free-runs while Run=1.

Test Plan:
- Reset: hold ClearSystem 3 cycles with Run=1.
  - Required: ClearCounter=1, EnableCount=0, Halted=0, IR=0x00 throughout.
  - Required: ClearCounter drops in the cycle after release.
- Sequential program 0x13, 0x22, 0x31, 0xF0 at PC 0..3, ROM_LAT=1.
  - Required: AccStrobe pulses with AccOp 00/01/10 and Operand 3/2/1, spaced 4 cycles apart.
  - Required: 3 EnableCount pulses, then Halted=1 with PC=3.
- JZ0 at PC=2.
  - AccZero=1: ClearCounter pulses for 1 cycle, no EnableCount, next fetch at PC=0.
  - AccZero=0: EnableCount pulses, next fetch at PC=3.
- Wrap: NOPs at PC 0..15.
  - WRAP_HALT=1: WrapFlag=1 and Halted=1 after the 16th EnableCount.
  - WRAP_HALT=0: WrapFlag=1 and execution continues at PC=0.
- Run deasserted during EXEC of 0x21.
  - Required: AccStrobe still fires and EnableCount pulses once, then IDLE. No further strobes until Run=1 again.
- VSM_SINGLE_STEP_EN defined, Run=1, 3 Step edges.
  - Required: exactly 3 EnableCount pulses and PC advances 0->3.
  - Required: holding Step high produces no extra instructions.
